// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter merging the fetch and data buses onto one
// single-beat memory port; one transaction in flight at a time.
module mem_arbiter #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [63:0]       dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [63:0]       dresp_data,
  output logic              mreq_valid,
  input  logic              mreq_ready,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [63:0]       mreq_data,
  input  logic              mresp_valid,
  input  logic [63:0]       mresp_data
);

  typedef enum logic [2:0] {
    IDLE,
    I_REQ,
    D_REQ,
    I_RESP,
    D_RESP
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state, state_d;
  logic   last_grant;
  logic   grant_i, grant_d;
  logic   i_done, d_done;

  // The response word is 8-byte aligned; a fetch takes the 32-bit half
  // selected by address bit 2.
  function automatic logic [31:0] fetch_lane(input logic hi, input logic [63:0] word);
    return hi ? word[63:32] : word[31:0];
  endfunction

  always_comb begin
    state_d       = state;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    iresp_addr_ok = 1'b0;
    dresp_addr_ok = 1'b0;
    case (state)
      IDLE: begin
        // With both pending, the client not served last wins.
        if (dreq_valid && (!ireq_valid || last_grant == GRANT_I)) begin
          grant_d = 1'b1;
          state_d = D_REQ;
        end else if (ireq_valid) begin
          grant_i = 1'b1;
          state_d = I_REQ;
        end
      end
      I_REQ: begin
        if (mreq_ready) begin
          iresp_addr_ok = 1'b1;
          state_d       = I_RESP;
        end
      end
      D_REQ: begin
        if (mreq_ready) begin
          dresp_addr_ok = 1'b1;
          state_d       = D_RESP;
        end
      end
      I_RESP: begin
        if (mresp_valid) state_d = IDLE;
      end
      D_RESP: begin
        if (mresp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mreq_valid = (state == I_REQ) || (state == D_REQ);
  assign i_done     = (state == I_RESP) && mresp_valid;
  assign d_done     = (state == D_RESP) && mresp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= GRANT_I;
      mreq_addr     <= '0;
      mreq_size     <= '0;
      mreq_strobe   <= '0;
      mreq_data     <= '0;
      iresp_data_ok <= 1'b0;
      dresp_data_ok <= 1'b0;
      iresp_data    <= '0;
      dresp_data    <= '0;
    end else begin
      state         <= state_d;
      iresp_data_ok <= i_done;
      dresp_data_ok <= d_done;
      if (grant_i) begin
        last_grant  <= GRANT_I;
        mreq_addr   <= ireq_addr;
        mreq_size   <= 3'b010;
        mreq_strobe <= 8'h00;
        mreq_data   <= 64'h0;
      end else if (grant_d) begin
        last_grant  <= GRANT_D;
        mreq_addr   <= dreq_addr;
        mreq_size   <= dreq_size;
        mreq_strobe <= dreq_strobe;
        mreq_data   <= dreq_data;
      end
      if (i_done) iresp_data <= fetch_lane(mreq_addr[2], mresp_data);
      if (d_done) dresp_data <= mresp_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level arbitration/memory model.
module tb_mem_arbiter;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_addr_ok, iresp_data_ok;
  logic [31:0]       iresp_data;
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [63:0]       dreq_data;
  logic              dresp_addr_ok, dresp_data_ok;
  logic [63:0]       dresp_data;
  logic              mreq_valid, mreq_ready;
  logic [ADDR_W-1:0] mreq_addr;
  logic [2:0]        mreq_size;
  logic [7:0]        mreq_strobe;
  logic [63:0]       mreq_data;
  logic              mresp_valid;
  logic [63:0]       mresp_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit grant_seq[$];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_addr(mreq_addr),
    .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_valid(mresp_valid), .mresp_data(mresp_data)
  );

  // Memory contents as a function of the 8-byte-aligned address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [31:0] b;
    b = {a[31:3], 3'b000};
    return {b ^ 32'hC3A5_5A3C, b + 32'h0F1E_2D3C};
  endfunction

  task automatic drive_idle();
    ireq_valid  = 1'b0; ireq_addr  = '0;
    dreq_valid  = 1'b0; dreq_addr  = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    mreq_ready  = 1'b0; mresp_valid = 1'b0; mresp_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; drive_idle();
    @(negedge clk);
    @(negedge clk); rst = 1'b0; mreq_ready = 1'b1; mresp_valid = 1'b1; mresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    n_tests++;
    if ({mreq_valid, iresp_addr_ok, dresp_addr_ok, iresp_data_ok, dresp_data_ok} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000",
        {mreq_valid, iresp_addr_ok, dresp_addr_ok, iresp_data_ok, dresp_data_ok});
    end
    n_tests++;
    if ({iresp_data, dresp_data} !== 96'h0) begin
      n_fail++; $display("FAIL reset_resp_data: got i=%h d=%h want 0", iresp_data, dresp_data);
    end
    n_tests++;
    if ({mreq_addr, mreq_size, mreq_strobe, mreq_data} !== '0) begin
      n_fail++; $display("FAIL reset_mreq_fields: got a=%h s=%h st=%h d=%h want 0",
        mreq_addr, mreq_size, mreq_strobe, mreq_data);
    end
  endtask

  task automatic test_dread();
    @(negedge clk); drive_idle();
    dreq_valid = 1'b1; dreq_addr = 64'h8000_0010; dreq_size = 3'b011; dreq_data = 64'h5555_AAAA_5555_AAAA;
    #1;
    n_tests++;
    if (mreq_valid !== 1'b0) begin n_fail++; $display("FAIL dread_c0_mreq_valid: got %b want 0", mreq_valid); end
    @(negedge clk); mreq_ready = 1'b1; #1;
    n_tests++;
    if ({mreq_valid, dresp_addr_ok, iresp_addr_ok} !== 3'b110) begin
      n_fail++; $display("FAIL dread_c1_handshake: got %b want 110", {mreq_valid, dresp_addr_ok, iresp_addr_ok});
    end
    n_tests++;
    if ({mreq_addr, mreq_size, mreq_strobe} !== {64'h8000_0010, 3'b011, 8'h00}) begin
      n_fail++; $display("FAIL dread_c1_fields: got a=%h s=%h st=%h want 80000010/3/00", mreq_addr, mreq_size, mreq_strobe);
    end
    @(negedge clk); dreq_valid = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 64'h1122_3344_5566_7788; #1;
    n_tests++;
    if ({mreq_valid, iresp_addr_ok, dresp_addr_ok, iresp_data_ok, dresp_data_ok} !== 5'b0) begin
      n_fail++; $display("FAIL dread_c2_quiet: got %b want 00000",
        {mreq_valid, iresp_addr_ok, dresp_addr_ok, iresp_data_ok, dresp_data_ok});
    end
    @(negedge clk); mresp_valid = 1'b0; mresp_data = '0; #1;
    n_tests++;
    if ({dresp_data_ok, iresp_data_ok, dresp_data} !== {2'b10, 64'h1122_3344_5566_7788}) begin
      n_fail++; $display("FAIL dread_c3_data: got ok=%b%b d=%h want 10 1122334455667788", dresp_data_ok, iresp_data_ok, dresp_data);
    end
  endtask

  task automatic do_fetch(input logic [63:0] addr, input logic [63:0] word, input logic [31:0] exp);
    @(negedge clk); drive_idle(); ireq_valid = 1'b1; ireq_addr = addr; #1;
    @(negedge clk); mreq_ready = 1'b1; #1;
    n_tests++;
    if ({mreq_valid, iresp_addr_ok, dresp_addr_ok, mreq_addr, mreq_size, mreq_strobe} !== {3'b110, addr, 3'b010, 8'h00}) begin
      n_fail++; $display("FAIL fetch_req: got v/ok=%b%b%b a=%h s=%h st=%h want 110 %h 2 00",
        mreq_valid, iresp_addr_ok, dresp_addr_ok, mreq_addr, mreq_size, mreq_strobe, addr);
    end
    @(negedge clk); ireq_valid = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = word; #1;
    @(negedge clk); mresp_valid = 1'b0; mresp_data = '0; #1;
    n_tests++;
    if ({iresp_data_ok, dresp_data_ok, iresp_data} !== {2'b10, exp}) begin
      n_fail++; $display("FAIL fetch_data: got ok=%b%b d=%h want 10 %h", iresp_data_ok, dresp_data_ok, iresp_data, exp);
    end
  endtask

  task automatic test_fetch_lanes();
    do_fetch(64'h8000_0004, 64'hAAAA_AAAA_BBBB_BBBB, 32'hAAAA_AAAA);
    do_fetch(64'h8000_0000, 64'hAAAA_AAAA_BBBB_BBBB, 32'hBBBB_BBBB);
  endtask

  task automatic test_write_stall();
    logic [63:0] a = 64'h8000_0208;
    logic [63:0] d = 64'hCAFE_F00D_1234_5678;
    @(negedge clk); drive_idle();
    dreq_valid = 1'b1; dreq_addr = a; dreq_size = 3'b011; dreq_strobe = 8'h0F; dreq_data = d; #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); mreq_ready = (c == 4); #1;
      n_tests++;
      if ({mreq_valid, iresp_addr_ok, dresp_addr_ok} !== {2'b10, (c == 4)}) begin
        n_fail++; $display("FAIL wstall_handshake_c%0d: got %b%b%b want 10%0d", c, mreq_valid, iresp_addr_ok, dresp_addr_ok, (c == 4));
      end
      n_tests++;
      if ({mreq_addr, mreq_size, mreq_strobe, mreq_data} !== {a, 3'b011, 8'h0F, d}) begin
        n_fail++; $display("FAIL wstall_fields_c%0d: got a=%h s=%h st=%h d=%h", c, mreq_addr, mreq_size, mreq_strobe, mreq_data);
      end
    end
    @(negedge clk); dreq_valid = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 64'h0123_4567_89AB_CDEF; #1;
    n_tests++;
    if ({mreq_valid, dresp_addr_ok} !== 2'b00) begin
      n_fail++; $display("FAIL wstall_single_pulse: got %b%b want 00", mreq_valid, dresp_addr_ok);
    end
    @(negedge clk); mresp_valid = 1'b0; #1;
    n_tests++;
    if ({dresp_data_ok, iresp_data_ok} !== 2'b10) begin
      n_fail++; $display("FAIL wstall_data_ok: got %b%b want 10", dresp_data_ok, iresp_data_ok);
    end
  endtask

  task automatic test_spurious();
    @(negedge clk); drive_idle(); mresp_valid = 1'b1; mresp_data = 64'hDEAD_BEEF_DEAD_BEEF; #1;
    @(negedge clk); mresp_valid = 1'b0; #1;
    n_tests++;
    if ({mreq_valid, iresp_data_ok, dresp_data_ok} !== 3'b000) begin
      n_fail++; $display("FAIL spur_idle: got %b want 000", {mreq_valid, iresp_data_ok, dresp_data_ok});
    end
    @(negedge clk); ireq_valid = 1'b1; ireq_addr = 64'h8000_0100; #1;
    @(negedge clk); mresp_valid = 1'b1; mresp_data = 64'h0BAD_0BAD_0BAD_0BAD; #1;
    n_tests++;
    if ({mreq_valid, iresp_addr_ok} !== 2'b10) begin
      n_fail++; $display("FAIL spur_req_c1: got %b%b want 10", mreq_valid, iresp_addr_ok);
    end
    @(negedge clk); mresp_valid = 1'b0; #1;
    n_tests++;
    if ({mreq_valid, iresp_addr_ok, iresp_data_ok, dresp_data_ok} !== 4'b1000) begin
      n_fail++; $display("FAIL spur_req_c2: got %b want 1000", {mreq_valid, iresp_addr_ok, iresp_data_ok, dresp_data_ok});
    end
    @(negedge clk); mreq_ready = 1'b1; #1;
    n_tests++;
    if (iresp_addr_ok !== 1'b1) begin n_fail++; $display("FAIL spur_addr_ok: got %b want 1", iresp_addr_ok); end
    @(negedge clk); ireq_valid = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 64'h7777_6666_5555_4444; #1;
    @(negedge clk); mresp_valid = 1'b0; #1;
    n_tests++;
    if ({iresp_data_ok, iresp_data} !== {1'b1, 32'h5555_4444}) begin
      n_fail++; $display("FAIL spur_fetch_done: got ok=%b d=%h want 1 55554444", iresp_data_ok, iresp_data);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive_idle(); dreq_valid = 1'b1; dreq_addr = 64'h8000_0040; dreq_size = 3'b011; #1;
    @(negedge clk); mreq_ready = 1'b1; #1;
    @(negedge clk); dreq_valid = 1'b0; mreq_ready = 1'b0; rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; mresp_valid = 1'b1; mresp_data = 64'h9999_8888_7777_6666; #1;
    n_tests++;
    if ({mreq_valid, iresp_addr_ok, dresp_addr_ok, iresp_data_ok, dresp_data_ok, iresp_data, dresp_data,
         mreq_addr, mreq_size, mreq_strobe, mreq_data} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got v=%b d=%h a=%h want all 0", mreq_valid, dresp_data, mreq_addr);
    end
    @(negedge clk); mresp_valid = 1'b0; #1;
    n_tests++;
    if ({dresp_data_ok, iresp_data_ok, mreq_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_late_resp: got %b want 000", {dresp_data_ok, iresp_data_ok, mreq_valid});
    end
    do_fetch(64'h8000_0008, 64'h1357_9BDF_2468_ACE0, 32'h2468_ACE0);
  endtask

  // Cycle-by-cycle traffic against a transaction-level model: phase 0 idle,
  // 1 request issued to memory, 2 waiting for the memory beat.
  task automatic run_traffic(input int ncyc, input bit sat);
    logic        i_pend = 1'b0, d_pend = 1'b0;
    logic [63:0] i_addr = '0, d_addr = '0, d_data = '0;
    logic [2:0]  d_size = '0;
    logic [7:0]  d_strb = '0;
    int          phase = 0;
    logic        cur_d = 1'b0, last_d = 1'b0;
    logic [63:0] x_addr = '0;
    logic        e_idok = 1'b0, e_ddok = 1'b0;
    logic [31:0] e_idata = '0;
    logic [63:0] e_ddata = '0;
    logic [4:0]  e_ctrl;
    grant_seq.delete();
    @(negedge clk); rst = 1'b1; drive_idle();
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (!i_pend && (sat || $urandom_range(0, 3) == 0)) begin
        i_pend = 1'b1; i_addr = {$urandom, $urandom & 32'hFFFF_FFFC};
      end
      if (!d_pend && (sat || $urandom_range(0, 3) == 0)) begin
        d_pend = 1'b1; d_addr = {$urandom, $urandom}; d_size = 3'($urandom_range(0, 3));
        d_strb = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00; d_data = {$urandom, $urandom};
      end
      ireq_valid = i_pend; ireq_addr = i_pend ? i_addr : {$urandom, $urandom};
      dreq_valid = d_pend; dreq_addr = d_addr; dreq_size = d_size; dreq_strobe = d_strb; dreq_data = d_data;
      mreq_ready  = sat ? 1'b1 : ($urandom_range(0, 2) != 0);
      mresp_valid = sat ? 1'b1 : ($urandom_range(0, 2) == 0);
      mresp_data  = (phase == 2 && mresp_valid) ? mem_word(x_addr) : {$urandom, $urandom};
      #1;
      e_ctrl = {phase == 1, phase == 1 && !cur_d && mreq_ready, phase == 1 && cur_d && mreq_ready, e_idok, e_ddok};
      n_tests++;
      if ({mreq_valid, iresp_addr_ok, dresp_addr_ok, iresp_data_ok, dresp_data_ok} !== e_ctrl) begin
        n_fail++; $display("FAIL traffic_ctrl@%0d: got v/iaok/daok/idok/ddok=%b want %b", c,
          {mreq_valid, iresp_addr_ok, dresp_addr_ok, iresp_data_ok, dresp_data_ok}, e_ctrl);
      end
      if (phase == 1) begin
        n_tests++;
        if (cur_d ? ({mreq_addr, mreq_size, mreq_strobe, mreq_data} !== {d_addr, d_size, d_strb, d_data})
                  : ({mreq_addr, mreq_size, mreq_strobe} !== {i_addr, 3'b010, 8'h00})) begin
          n_fail++; $display("FAIL traffic_fields@%0d: client=%0d got a=%h s=%h st=%h", c, cur_d, mreq_addr, mreq_size, mreq_strobe);
        end
      end
      if (e_idok) begin
        n_tests++;
        if (iresp_data !== e_idata) begin n_fail++; $display("FAIL traffic_idata@%0d: got %h want %h", c, iresp_data, e_idata); end
      end
      if (e_ddok) begin
        n_tests++;
        if (dresp_data !== e_ddata) begin n_fail++; $display("FAIL traffic_ddata@%0d: got %h want %h", c, dresp_data, e_ddata); end
      end
      e_idok = 1'b0; e_ddok = 1'b0;
      case (phase)
        0: if (i_pend || d_pend) begin
             cur_d = d_pend && (!i_pend || !last_d);
             last_d = cur_d; phase = 1; grant_seq.push_back(cur_d);
           end
        1: if (mreq_ready) begin
             x_addr = cur_d ? d_addr : i_addr; phase = 2;
             if (cur_d) d_pend = 1'b0; else i_pend = 1'b0;
           end
        default: if (mresp_valid) begin
             phase = 0;
             if (cur_d) begin e_ddok = 1'b1; e_ddata = mem_word(x_addr); end
             else begin
               e_idok = 1'b1;
               e_idata = x_addr[2] ? mem_word(x_addr) >> 32 : 32'(mem_word(x_addr));
             end
           end
      endcase
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic test_alternate();
    bit exp_seq[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    run_traffic(40, 1'b1);
    n_tests++;
    if (grant_seq.size() < 4) begin
      n_fail++; $display("FAIL alt_grant_count: got %0d want >=4", grant_seq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (grant_seq[k] !== exp_seq[k]) begin
          n_fail++; $display("FAIL alt_order_%0d: got %0d want %0d (1=D)", k, grant_seq[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    run_traffic(3000, 1'b0);
    n_tests++;
    if (grant_seq.size() < 100) begin
      n_fail++; $display("FAIL random_progress: got %0d grants want >=100", grant_seq.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_dread();
    test_fetch_lanes();
    test_write_stall();
    test_spurious();
    test_reset_mid();
    test_alternate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
